capture_sequencer: RTL and testbench
====================================

# capture_sequencer

Register-programmed run controller for the logic-analyzer sampler pipeline. It arms the pipeline, fills a pre-trigger window, waits for a pattern trigger on the synchronized sample word, captures a post-trigger window, then drains the pipeline and signals completion. It owns the pipeline's `run` and `clear` controls in place of direct software writes, and sits on the same 6-bit register bus as the sampler.

## Interface
- `CNT_W`, default 32: width of the pre-count, post-count and captured-count counters (≤32).

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `trig_data`  in  16  synchronized sample word; valid when `sample_strobe` is high.
- `sample_strobe`  in  1  one-cycle pulse per accepted sample.
- `overflow`  in  1  sticky pipeline overflow (serializer/compressor/output).
- `pipeline_busy`  in  1  high while the serializer or compressor has an output in flight.
- `run`  out  1  sampler enable.
- `clear`  out  1  one-cycle pipeline and timer clear pulse.
- `done_irq`  out  1  one-cycle completion pulse.
- `avalid`, `awe`  in  1  bus request and write enable.
- `aaddr`  in  6  byte address; bits [1:0] are ignored.
- `adata`  in  32  write data.
- `bvalid`  out  1  read/write acknowledge.
- `bdata`  out  32  read data.

## Operation
- Registers:
  - 0x00 CTRL. Write: bit0 `start`, bit1 `abort`. Read: {22'b0, ovf[9], trig[8], 5'b0, state[2:0]}.
  - 0x04 TRIG. [15:0] mask, [31:16] value.
  - 0x08 PRE_COUNT.
  - 0x0C POST_COUNT.
  - 0x10 CAPTURED. Read-only count of strobes seen while `run` is high; saturates at all-ones.
  - Unmapped reads return 0.
- State encoding: IDLE=0, CLEAR=1, PRE=2, WAIT=3, POST=4, FLUSH=5, DONE=6.
- IDLE/DONE + `start`:
  - Enter CLEAR, assert `clear` for exactly one cycle with `run` low.
  - Zero CAPTURED, the counters, `trig` and `ovf`.
- CLEAR: always goes to PRE the next cycle; `run` is high from the PRE entry onward.
- PRE: count strobes. When the count equals PRE_COUNT, go to WAIT. PRE_COUNT=0 passes through PRE in a single cycle.
- WAIT: a strobe with ((trig_data ^ value) & mask)==0 sets `trig` and goes to POST. The trigger sample is not counted in POST. Mask=0 triggers on the first strobe.
- POST: count strobes. On the strobe that makes the count equal POST_COUNT, go to FLUSH. POST_COUNT=0 goes to FLUSH on the cycle after entry.
- FLUSH: `run` is low. Stay until `pipeline_busy` has been low for 2 consecutive cycles, then go to DONE and pulse `done_irq`.
- `overflow` high in PRE, WAIT or POST: set `ovf` and go to FLUSH.
- `abort`: any state goes to IDLE next cycle, with `run` low and no `done_irq`. If `abort` and `start` are in the same write, `abort` wins.
- `start` in CLEAR through FLUSH is ignored.
- Counter arithmetic is unsigned `CNT_W` bits, compared for equality; no wrap is reachable before the compare hits.
- Register writes to 0x04–0x0C take effect immediately, including mid-run.

## Timing
- Reset values:
  - Outputs: `run`=0, `clear`=0, `done_irq`=0, `bvalid`=0, `bdata`=0.
  - State: IDLE. All registers and counters: 0.
- `bvalid` follows `avalid` by one cycle; `bdata` is registered (1-cycle read latency).
- Write-to-`clear` latency: `start` is written in cycle N, `clear` is high in N+1, `run` is high from N+2.
- `run` falls in the cycle after the terminating strobe, or after `overflow`/`abort` is seen.
- A strobe in the same cycle as a state transition is counted in the old state only.
- Asynchronous reset mid-run drops `run` immediately and returns to IDLE.

## Configuration
- `CAPTURE_SEQ_EDGE_TRIG_EN`
  - Defined:
    - Adds register 0x14 EDGE_MASK[15:0].
    - In WAIT, a strobe where (trig_data ^ previous strobed word) & EDGE_MASK is nonzero also triggers.
    - The previous word is captured on every strobe while `run` is high.
    - No edge trigger is possible on the first strobe after `start`.
  - Undefined: 0x14 reads 0, writes are ignored, and only the pattern trigger exists.

## Test plan
- PRE=3, POST=2, mask=0x00FF, value=0x0012; strobes with words 1,2,3,4,0x3412,5,6 -> trigger on 0x3412, `run` falls after the strobe of 6, CAPTURED=7, `done_irq` once.
- PRE=0, POST=0, mask=0 -> trigger on the 1st strobe, FLUSH next cycle, CAPTURED=1.
- `overflow` asserted in WAIT -> state 5, status bit9=1, no trigger, DONE after 2 idle cycles of `pipeline_busy`.
- Write CTRL=0x3 mid-POST -> IDLE, `run`=0 next cycle, no `done_irq`; a second `start` in POST is ignored.
- `pipeline_busy` held high for 10 cycles in FLUSH -> `done_irq` exactly 2 cycles after it drops.
- With EDGE_TRIG_EN: EDGE_MASK=0x0001, mask=0, words 0,0,1 in WAIT entered after PRE=0 -> triggers on the first word (pattern); with mask=0xFFFF, value=0xFFFF, words 0,0,1 -> trigger on word 1.

Source files
------------

// File: rtl/capture_sequencer.sv
// capture_sequencer: register-programmed arm/pre-trigger/trigger/post-trigger/flush run controller.
// Optional edge trigger (EDGE_MASK at 0x14) enabled by defining CAPTURE_SEQ_EDGE_TRIG_EN.
module capture_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] trig_data,
  input  logic        sample_strobe,
  input  logic        overflow,
  input  logic        pipeline_busy,
  output logic        run,
  output logic        clear,
  output logic        done_irq,
  input  logic        avalid,
  input  logic        awe,
  input  logic [5:0]  aaddr,
  input  logic [31:0] adata,
  output logic        bvalid,
  output logic [31:0] bdata
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam logic [2:0] S_FLUSH = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]       state, state_nx;
  logic [15:0]      mask, value;
  logic [CNT_W-1:0] pre_count, post_count, captured, cnt, cnt_inc;
  logic             trig, ovf, low_seen;
  logic             wr, start, abort, active, pat_hit, edge_hit, hit, go;
  logic [31:0]      rd_data;
  logic [1:0]       unused_addr;

  assign unused_addr = aaddr[1:0];
  assign wr       = avalid && awe;
  assign start    = wr && aaddr[5:2] == 4'd0 && adata[0];
  assign abort    = wr && aaddr[5:2] == 4'd0 && adata[1];
  assign active   = state == S_PRE || state == S_WAIT || state == S_POST;
  assign run      = active;
  assign clear    = state == S_CLEAR;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign pat_hit  = ((trig_data ^ value) & mask) == 16'd0;
  assign hit      = sample_strobe && (pat_hit || edge_hit);
  assign go       = state_nx == S_CLEAR;

`ifdef CAPTURE_SEQ_EDGE_TRIG_EN
  logic [15:0] edge_mask, prev_word;
  logic        prev_valid;
  // prev_valid keeps the first strobe after start from edge-triggering against stale data
  assign edge_hit = prev_valid && |((trig_data ^ prev_word) & edge_mask);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      edge_mask  <= '0;
      prev_word  <= '0;
      prev_valid <= 1'b0;
    end else begin
      if (wr && aaddr[5:2] == 4'd5) edge_mask <= adata[15:0];
      if (go) prev_valid <= 1'b0;
      else if (active && sample_strobe) begin
        prev_word  <= trig_data;
        prev_valid <= 1'b1;
      end
    end
`else
  assign edge_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: state_nx = start ? S_CLEAR : state;
      S_CLEAR:        state_nx = S_PRE;
      S_PRE:          state_nx = overflow ? S_FLUSH : (cnt == pre_count) ? S_WAIT : S_PRE;
      S_WAIT:         state_nx = overflow ? S_FLUSH : hit ? S_POST : S_WAIT;
      S_POST:         state_nx = (overflow || cnt == post_count || (sample_strobe && cnt_inc == post_count)) ? S_FLUSH : S_POST;
      S_FLUSH:        state_nx = (low_seen && !pipeline_busy) ? S_DONE : S_FLUSH;
      default:        state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_comb begin
    rd_data = '0;
    case (aaddr[5:2])
      4'd0: rd_data = {22'd0, ovf, trig, 5'd0, state};
      4'd1: rd_data = {value, mask};
      4'd2: rd_data = 32'(pre_count);
      4'd3: rd_data = 32'(post_count);
      4'd4: rd_data = 32'(captured);
`ifdef CAPTURE_SEQ_EDGE_TRIG_EN
      4'd5: rd_data = {16'd0, edge_mask};
`endif
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      mask       <= '0;
      value      <= '0;
      pre_count  <= '0;
      post_count <= '0;
      captured   <= '0;
      cnt        <= '0;
      trig       <= 1'b0;
      ovf        <= 1'b0;
      low_seen   <= 1'b0;
      done_irq   <= 1'b0;
      bvalid     <= 1'b0;
      bdata      <= '0;
    end else begin
      state    <= state_nx;
      done_irq <= state == S_FLUSH && state_nx == S_DONE;
      low_seen <= state == S_FLUSH && !pipeline_busy;
      bvalid   <= avalid;
      bdata    <= (avalid && !awe) ? rd_data : '0;
      if (wr && aaddr[5:2] == 4'd1) {value, mask} <= adata;
      if (wr && aaddr[5:2] == 4'd2) pre_count <= adata[CNT_W-1:0];
      if (wr && aaddr[5:2] == 4'd3) post_count <= adata[CNT_W-1:0];
      if (go) begin
        cnt      <= '0;
        captured <= '0;
        trig     <= 1'b0;
        ovf      <= 1'b0;
      end else begin
        if (active && sample_strobe && captured != '1) captured <= captured + CNT_W'(1);
        if (state == S_WAIT && state_nx == S_POST) begin
          trig <= 1'b1;
          cnt  <= '0;
        end else if ((state == S_PRE || state == S_POST) && sample_strobe) cnt <= cnt_inc;
        if (active && overflow) ovf <= 1'b1;
      end
    end
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: randomized and directed runs checked against a word-list outcome model.
module tb_capture_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] trig_data = '0;
  logic        sample_strobe = 1'b0, overflow = 1'b0, pipeline_busy = 1'b0;
  logic        run, clear, done_irq, bvalid;
  logic        avalid = 1'b0, awe = 1'b0;
  logic [5:0]  aaddr = '0;
  logic [31:0] adata = '0, bdata, rdv;
  int          checks = 0, errors = 0, done_cnt = 0;
  logic [15:0] words[$];
  logic [15:0] edge_m = '0;

  capture_sequencer dut (
    .clk(clk), .rst_n(rst_n), .trig_data(trig_data), .sample_strobe(sample_strobe),
    .overflow(overflow), .pipeline_busy(pipeline_busy), .run(run), .clear(clear),
    .done_irq(done_irq), .avalid(avalid), .awe(awe), .aaddr(aaddr), .adata(adata),
    .bvalid(bvalid), .bdata(bdata)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done_irq) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
    avalid = 1'b1; awe = 1'b1; aaddr = a; adata = d;
    tick();
    avalid = 1'b0; awe = 1'b0;
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
    avalid = 1'b1; awe = 1'b0; aaddr = a;
    tick();
    avalid = 1'b0;
    check("bvalid", {31'd0, bvalid}, 32'd1);
    d = bdata;
  endtask

  task automatic strobe(input logic [15:0] w);
    sample_strobe = 1'b1; trig_data = w;
    tick();
    sample_strobe = 1'b0;
  endtask

  // First word at or after the pre-trigger window that satisfies the pattern or edge rule
  function automatic int find_trig(input int pre, input logic [15:0] msk, input logic [15:0] val);
    for (int i = pre; i < words.size(); i++)
      if (((words[i] ^ val) & msk) == 16'd0 || (i > 0 && ((words[i] ^ words[i-1]) & edge_m) != 16'd0))
        return i;
    return -1;
  endfunction

  task automatic do_run(input int pre, input int post, input logic [15:0] msk,
                        input logic [15:0] val, input int hold);
    int t, term, d0;
    repeat (3) words.push_back(16'($urandom));
    t = find_trig(pre, msk, val);
    term = t + post;
    d0 = done_cnt;
    pipeline_busy = 1'b1;
    bus_wr(6'h04, {val, msk});
    bus_wr(6'h08, pre);
    bus_wr(6'h0C, post);
    bus_wr(6'h00, 32'h1);
    check("clear_hi", {30'd0, clear, run}, 32'h2);
    tick();
    check("run_hi_after_clear", {30'd0, clear, run}, 32'h1);
    tick();
    for (int i = 0; i <= term + 2; i++) begin
      if (i <= term) check("run_during", {31'd0, run}, 32'd1);
      strobe(words[i]);
      if (i == term) begin
        if (post == 0) begin
          check("run_post0", {31'd0, run}, 32'd1);
          tick();
        end
        check("run_fall", {31'd0, run}, 32'd0);
      end
      tick($urandom_range(1, 3));
    end
    bus_rd(6'h00, rdv);
    check("ctrl_flush", rdv, 32'h105);
    tick(hold);
    pipeline_busy = 1'b0;
    tick();
    check("done_early", {31'd0, done_irq}, 32'd0);
    tick();
    check("done_irq", {31'd0, done_irq}, 32'd1);
    tick();
    check("done_pulse", {31'd0, done_irq}, 32'd0);
    bus_rd(6'h00, rdv);
    check("ctrl_done", rdv, 32'h106);
    bus_rd(6'h10, rdv);
    check("captured", rdv, term + 1);
    check("done_count", done_cnt - d0, 32'd1);
  endtask

  initial begin
    int pre, post, d0;
    logic [15:0] msk, val;
    tick(2);
    check("rst_outputs", {27'd0, run, clear, done_irq, bvalid, |bdata}, 32'd0);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 6; a++) begin
      bus_rd(6'(a * 4), rdv);
      check("rst_reg", rdv, 32'd0);
    end
    bus_wr(6'h14, 32'hFFFF);
    bus_rd(6'h14, rdv);
`ifdef CAPTURE_SEQ_EDGE_TRIG_EN
    check("edge_mask_rw", rdv, 32'hFFFF);
    bus_wr(6'h14, 32'h0);
`else
    check("edge_mask_absent", rdv, 32'd0);
`endif

    words = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h3412, 16'h5, 16'h6};
    do_run(3, 2, 16'h00FF, 16'h0012, 3);
    words = '{16'h5555, 16'h1234};
    do_run(0, 0, 16'h0000, 16'h0000, 0);
    words = '{16'h1, 16'h2, 16'h3, 16'hABCD, 16'h9};
    do_run(1, 1, 16'hFFFF, 16'hABCD, 10);

    for (int r = 0; r < 8; r++) begin
      pre  = $urandom_range(0, 4);
      post = $urandom_range(0, 4);
      msk  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      val  = 16'($urandom);
      words = {};
      for (int i = 0; i < 16; i++) words.push_back(16'($urandom));
      words[pre + $urandom_range(0, 4)] = (val & msk) | (16'($urandom) & ~msk);
      do_run(pre, post, msk, val, $urandom_range(0, 10));
    end

    // overflow while waiting for a trigger that never comes
    d0 = done_cnt;
    pipeline_busy = 1'b1;
    bus_wr(6'h04, 32'hFFFF_FFFF);
    bus_wr(6'h08, 32'd0);
    bus_wr(6'h00, 32'h1);
    tick(3);
    strobe(16'h1);
    tick();
    strobe(16'h2);
    tick();
    overflow = 1'b1;
    tick();
    overflow = 1'b0;
    check("ovf_run_low", {31'd0, run}, 32'd0);
    bus_rd(6'h00, rdv);
    check("ctrl_ovf", rdv, 32'h205);
    pipeline_busy = 1'b0;
    tick(2);
    check("ovf_done", {31'd0, done_irq}, 32'd1);
    bus_rd(6'h00, rdv);
    check("ctrl_ovf_done", rdv, 32'h206);
    bus_rd(6'h10, rdv);
    check("ovf_captured", rdv, 32'd2);
    check("ovf_done_count", done_cnt - d0, 32'd1);

    // abort mid-POST, with an ignored restart first
    d0 = done_cnt;
    pipeline_busy = 1'b1;
    bus_wr(6'h04, 32'h0);
    bus_wr(6'h0C, 32'd5);
    bus_wr(6'h00, 32'h1);
    tick(3);
    strobe(16'h77);
    tick();
    strobe(16'h78);
    tick();
    bus_wr(6'h00, 32'h1);
    bus_rd(6'h00, rdv);
    check("restart_ignored", rdv, 32'h104);
    bus_wr(6'h00, 32'h3);
    check("abort_run_low", {31'd0, run}, 32'd0);
    bus_rd(6'h00, rdv);
    check("abort_idle", rdv & 32'h7, 32'd0);
    pipeline_busy = 1'b0;
    tick(6);
    check("abort_no_done", done_cnt - d0, 32'd0);

`ifdef CAPTURE_SEQ_EDGE_TRIG_EN
    edge_m = 16'h0001;
    bus_wr(6'h14, 32'h1);
    words = '{16'h0, 16'h0, 16'h1};
    do_run(0, 0, 16'h0000, 16'h0000, 0);
    words = '{16'h0, 16'h0, 16'h1};
    do_run(0, 0, 16'hFFFF, 16'hFFFF, 1);
`endif

    // asynchronous reset while waiting
    pipeline_busy = 1'b1;
    bus_wr(6'h04, 32'hFFFF_FFFF);
    bus_wr(6'h08, 32'd2);
    bus_wr(6'h00, 32'h1);
    tick(3);
    check("pre_reset_run", {31'd0, run}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_run", {31'd0, run}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus_rd(6'h00, rdv);
    check("reset_ctrl", rdv, 32'd0);
    bus_rd(6'h08, rdv);
    check("reset_pre", rdv, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
